smm_mul_arb: RTL
================

# smm_mul_arb

Round-robin arbiter and pipeline scheduler sharing one registered 32x32 unsigned multiplier (1-cycle latency, `ce`-gated output register) among `NUM_REQ` requesters in the SMM compute path. Each requester submits operand pairs over a valid/ready handshake. The block drives the multiplier's operands and `ce`, and tracks issued operations with a valid/ID shadow pipeline. It returns each 64-bit product on a single tagged response channel with backpressure that freezes the multiplier.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: operand width; product width is `2*DATA_W`.
- `MUL_LAT`, 1: multiplier latency in `ce`-enabled cycles; must match the attached multiplier.
- `ID_W`, 2: requester index width, `$clog2(NUM_REQ)`.
- `clk`, in, 1: single clock; all logic is rising-edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, `NUM_REQ`: per-requester operand valid.
- `req_ready`, out, `NUM_REQ`: per-requester accept; at most one bit set (one-hot).
- `req_a`, in, `NUM_REQ*DATA_W`: flattened operand A; requester i occupies `[i*DATA_W +: DATA_W]`.
- `req_b`, in, `NUM_REQ*DATA_W`: flattened operand B, same layout.
- `mul_din0`, out, `DATA_W`: to multiplier `din0`.
- `mul_din1`, out, `DATA_W`: to multiplier `din1`.
- `mul_ce`, out, 1: to multiplier `ce`.
- `mul_dout`, in, `2*DATA_W`: from multiplier `dout`.
- `rsp_valid`, out, 1: product available.
- `rsp_id`, out, `ID_W`: requester index of the product.
- `rsp_data`, out, `2*DATA_W`: product; wired directly from `mul_dout`.
- `rsp_ready`, in, 1: consumer accepts the product.
- `perf_busy`, out, 32: count of cycles with an issue.
- `perf_stall`, out, 32: count of cycles frozen by backpressure.

## Operation
- Shadow pipeline: `MUL_LAT` stages, each holding `{vld, id}`. Stage 0 loads the issue; the last stage drives `rsp_valid` and `rsp_id`.
- `mul_ce = !rsp_valid || rsp_ready`. With `mul_ce` low, the shadow pipeline and the multiplier both hold, so `rsp_data` stays stable.
- Arbitration: round-robin over `req_valid`, searching from `ptr`. Evaluated only when `mul_ce` is high.
  - The winner w gets `req_ready[w]=1`.
  - `mul_din0`/`mul_din1` are driven with w's operands.
  - Stage 0 loads `{1, w}`.
  - `ptr <= w+1`, wrapping from `NUM_REQ-1` to 0.
- No valid request with `mul_ce` high: stage 0 loads `vld=0` (bubble); operand outputs are don't-care and driven 0; `ptr` holds.
- `mul_ce` low: all `req_ready` are 0 and `ptr` holds.
- `req_ready` depends combinationally on `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- A requester must hold `req_valid` and its operands stable until accepted; it is never dropped.
- Fairness: with all requesters continuously valid and no backpressure, each is granted exactly once every `NUM_REQ` cycles.
- Product is unsigned: `rsp_data = req_a * req_b` with full `2*DATA_W` bits, no truncation.
- Responses return in issue order.

## Timing
- Issue at edge k (handshake `req_valid[w] && req_ready[w]`). `rsp_valid` asserts after edge k+`MUL_LAT-1`+s, where s is the number of stalled cycles in between. With `MUL_LAT`=1 and no stall, the product is visible in the cycle immediately after the issue edge.
- Full throughput: one issue and one response per cycle with `rsp_ready` held high.
- Simultaneous response accept and new issue in the same cycle is required and allowed.
- Reset values: all shadow `vld`=0, `ptr`=0, `rsp_valid`=0, `rsp_id`=0, `req_ready`=0, `mul_ce`=1, `mul_din0`=`mul_din1`=0, perf counters 0.
- Reset asserted mid-operation: all in-flight operations are discarded and no response is produced for them. Multiplier contents are ignored because `vld` is cleared.
- Perf counters wrap modulo 2^32.

## Configuration
- `SMM_MUL_ARB_PERF_EN` defined:
  - `perf_busy` increments on each issue cycle.
  - `perf_stall` increments each cycle with `rsp_valid && !rsp_ready`.
- `SMM_MUL_ARB_PERF_EN` undefined: the counter logic is removed and both ports are tied to constant 0. Ports always exist.

## Test plan
- Single request: requester 2 with a=0xFFFFFFFF, b=0xFFFFFFFF, `rsp_ready`=1 -> `rsp_valid` one cycle later, `rsp_id`=2, `rsp_data`=0xFFFFFFFE00000001.
- All four requesters valid continuously, `rsp_ready`=1 -> grants 0,1,2,3,0,... one per cycle; products match a*b per ID; `perf_busy`=N after N cycles.
- Backpressure: `rsp_ready`=0 for 5 cycles with a response pending -> `rsp_data`/`rsp_id` stable, `req_ready`=0, `mul_ce`=0, `perf_stall`=5; on release, stream resumes in order with no loss or duplication.
- Wrap/fairness: only requesters 3 and 0 valid, `ptr`=3 -> grants alternate 3,0,3,0.
- Reset asserted while 1 op is in flight and `rsp_valid`=1 -> outputs take their reset values immediately (asynchronously); no response after release until a new issue.
- Randomized valid/ready with a=0, b=x and a=1, b=x corner operands -> scoreboard matches exact unsigned products and per-requester order.

Source files
------------

// File: rtl/smm_mul_arb.sv
// Round-robin arbiter that time-shares one registered, ce-gated multiplier among
// NUM_REQ requesters. Optional perf counters are built when SMM_MUL_ARB_PERF_EN is defined.
module smm_mul_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 1,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]         mul_din0,
  output logic [DATA_W-1:0]         mul_din1,
  output logic                      mul_ce,
  input  logic [2*DATA_W-1:0]       mul_dout,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [2*DATA_W-1:0]       rsp_data,
  input  logic                      rsp_ready,
  output logic [31:0]               perf_busy,
  output logic [31:0]               perf_stall
);

  // Handshakes: a requester transfer happens on a rising edge where
  // req_valid[i] && req_ready[i]; a response transfer where rsp_valid && rsp_ready.
  // A stalled response freezes the multiplier and the shadow pipeline together.

  logic [ID_W-1:0]    r_ptr;
  logic [MUL_LAT-1:0] r_vld;
  logic [ID_W-1:0]    r_id [MUL_LAT];

  logic               w_ce;
  logic               w_found;
  logic               w_issue;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_ptr_nxt;

  assign w_ce      = !rsp_valid || rsp_ready;
  assign mul_ce    = w_ce;
  assign rsp_valid = r_vld[MUL_LAT-1];
  assign rsp_id    = r_id[MUL_LAT-1];
  assign rsp_data  = mul_dout;

  // Scan from the highest offset down so the requester nearest ptr wins last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_win   = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Grants are masked while reset is held so the ports show their reset values.
  assign w_issue   = w_ce && w_found && reset;
  assign w_ptr_nxt = (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    if (w_issue) begin
      req_ready[w_win] = 1'b1;
      mul_din0         = req_a[int'(w_win)*DATA_W +: DATA_W];
      mul_din1         = req_b[int'(w_win)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (w_issue) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Shadow pipeline mirrors the multiplier's ce-gated stages with {vld, id}.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        r_id[i] <= '0;
      end
    end else if (w_ce) begin
      r_vld[0] <= w_issue;
      r_id[0]  <= w_issue ? w_win : '0;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end

`ifdef SMM_MUL_ARB_PERF_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_issue) begin
        r_perf_busy <= r_perf_busy + 32'd1;
      end
      if (rsp_valid && !rsp_ready) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_busy  = r_perf_busy;
  assign perf_stall = r_perf_stall;
`else
  assign perf_busy  = '0;
  assign perf_stall = '0;
`endif

endmodule
